period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 89 ++++++++
 1 files changed

// File: rtl/period_meter.sv
// Measures the period of a slow, already-synchronous input (fin) in clk cycles,
// flags lock after LOCK_CNT identical periods and reports a timeout on counter saturation.
module period_meter #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fin,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_M  = 4'(LOCK_CNT);

    state_t           state_reg;
    logic             fin_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] ref_reg;
    logic [3:0]       m_reg;
    logic [3:0]       m_next;
    logic             fin_rise;

    assign fin_rise = fin & ~fin_d_reg;

    // m_reg == 0 marks the first measurement after IDLE, which always restarts the run.
    always_comb begin
        m_next = 4'd1;
        if ((m_reg != 4'd0) && (cnt_reg == ref_reg)) begin
            m_next = (m_reg >= LOCK_M) ? LOCK_M : m_reg + 4'd1;
        end
    end

    // fin_d resets high so a fin already high at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fin_d_reg    <= 1'b1;
            cnt_reg      <= '0;
            ref_reg      <= '0;
            m_reg        <= 4'd0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            fin_d_reg    <= fin;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fin_rise) begin
                        cnt_reg   <= CNT_ONE;
                        state_reg <= MEAS;
                    end
                end
                MEAS: begin
                    if (fin_rise) begin
                        period       <= cnt_reg;
                        period_valid <= 1'b1;
                        cnt_reg      <= CNT_ONE;
                        ref_reg      <= cnt_reg;
                        m_reg        <= m_next;
                        locked       <= (m_next >= LOCK_M);
                    end else if (cnt_reg == CNT_MAX) begin
                        // Saturated without an edge: drop the run, keep period and ref.
                        timeout   <= 1'b1;
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        m_reg     <= 4'd0;
                        locked    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule
